stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every input channel and on the output, a registered output stage, and round-robin arbitration. It supersedes the combinational 2:1 mux wherever several producers share one consumer. It also keeps a manual-select mode that behaves as a plain select-driven mux.

## Interface
Parameters:
- WIDTH, 8, data bits per channel.
- N, 4, number of input channels (N ≥ 2).
- SELW, $clog2(N), width of select/index fields (derived; do not override).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; combinational; at most one bit high.
- man_en  in  1  1 = manual select mode, 0 = arbitrated mode.
- man_sel  in  SELW  channel served when man_en = 1.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_ready  in  1  downstream ready.

## Operation
- Output register states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- load_ok = !out_valid | out_ready. The register accepts a new beat when empty or when draining in the same cycle.
- Grant g is combinational from in_valid, the mode and the pointer. in_ready[g] = load_ok & rst_n; all other in_ready bits are 0.
- Input transfer occurs when in_valid[g] & in_ready[g]. On that edge:
  - out_data ← channel g data; out_sel ← g; out_valid ← 1.
- Output transfer occurs when out_valid & out_ready. If no input transfers in the same cycle, out_valid ← 0 and out_data/out_sel hold their values.
- Arbitrated mode (man_en = 0):
  - Search starts at pointer ptr (SELW bits, reset 0) and proceeds upward, modulo N, to the first channel with in_valid set.
  - After an input transfer from g, ptr ← (g+1) mod N.
  - If no channel is valid, there is no grant and ptr holds.
- Manual mode (man_en = 1):
  - Grant = man_sel if in_valid[man_sel], otherwise no grant.
  - If man_sel ≥ N, there is never a grant.
  - ptr holds throughout manual mode.
  - Switching man_en or man_sel never corrupts a beat already in the output register.
- Reset mid-operation:
  - out_valid, out_data and out_sel clear immediately and any held beat is dropped.
  - ptr returns to 0.
  - in_ready is forced to 0 while rst_n = 0.
- Data is never duplicated or dropped while rst_n = 1.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
- Latency: an input beat transferred at edge t is visible on out_* after edge t.
- Throughput: one beat per cycle sustained while out_ready = 1.
- Backpressure:
  - With out_valid = 1 and out_ready = 0, all in_ready bits are 0 and out_* holds stable.
  - Simultaneous output drain and input load in one cycle passes a new beat with no bubble.
- Input handshake: a producer must hold in_valid/in_data until its in_ready is seen high. Deasserting in_valid without a transfer is permitted; the arbiter simply re-evaluates.
- There is no combinational path from out_ready to out_valid/out_data. The only combinational path is out_ready → in_ready.

## Configuration
- Macro: STREAM_MUX_RR_EN.
- Defined: round-robin arbitration as described above, with ptr implemented.
- Undefined:
  - Fixed priority: in arbitrated mode the lowest-index valid channel wins and ptr is not implemented.
  - Manual mode, handshakes and timing are unchanged.

## Test plan
All scenarios use N = 4, WIDTH = 8.
- Reset: hold rst_n = 0 with all in_valid = 1 → out_valid = 0, out_data = 0x00, out_sel = 0, in_ready = 4'b0000. Release with out_ready = 1 → first beat on out_* one cycle later, out_sel = 0.
- Round-robin, with STREAM_MUX_RR_EN defined: all channels valid with data 0x10/0x21/0x32/0x43 and out_ready = 1 → out_sel sequence 0,1,2,3,0 and out_data 0x10,0x21,0x32,0x43,0x10 on consecutive cycles. Without the macro → out_sel stays 0.
- Backpressure: out_valid = 1, out_ready = 0 for 5 cycles → out_* stable and in_ready = 0000. Raise out_ready → next beat loads the same cycle with no idle cycle.
- Manual: man_en = 1, man_sel = 2, only ch1 (0xAA) and ch2 (0x55) valid → only 0x55 forwarded with out_sel = 2. Setting man_sel = 3 with ch3 idle → out_valid drops after the drain and ch1 stays stalled.
- Reset mid-stream: assert rst_n = 0 while out_valid = 1 and out_ready = 0 → out_valid clears the same cycle without waiting for clk. After release, arbitration restarts from ch0.
- Sparse input: only ch3 valid, pulsed every other cycle → each beat appears one cycle later with out_sel = 3, and no beat is duplicated.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with a registered output stage and manual-select mode.
// STREAM_MUX_RR_EN selects round-robin arbitration; undefined gives fixed priority (lowest index wins).
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               man_en,
  input  logic [SELW-1:0]    man_sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);
  // state | meaning
  // EMPTY | no beat held, out_valid = 0
  // FULL  | beat held in the output register, out_valid = 1
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             load_ok, load, gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
`ifdef STREAM_MUX_RR_EN
  logic [SELW-1:0]  ptr;
  logic [2*N-1:0]   rot;
`endif

  assign out_valid = (state == FULL);
  assign load_ok   = !out_valid || out_ready;
  assign load      = gnt_vld && load_ok && rst_n;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
`ifdef STREAM_MUX_RR_EN
    rot = {in_valid, in_valid} >> ptr;
`endif
    if (man_en) begin
      // out-of-range man_sel matches no channel, so it never grants
      for (int k = 0; k < N; k++) begin
        if (SELW'(k) == man_sel && in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
    end else begin
`ifdef STREAM_MUX_RR_EN
      for (int k = 0; k < N; k++) begin
        if (!gnt_vld && rot[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = (int'(ptr) + k >= N) ? SELW'(int'(ptr) + k - N) : SELW'(int'(ptr) + k);
        end
      end
`else
      for (int k = 0; k < N; k++) begin
        if (!gnt_vld && in_valid[k]) begin
          gnt_vld = 1'b1;
          gnt_idx = SELW'(k);
        end
      end
`endif
    end
  end

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int k = 0; k < N; k++) begin
      if (SELW'(k) == gnt_idx) begin
        gnt_data    = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = gnt_vld && load_ok && rst_n;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = FULL;
    else if (state == FULL && out_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (load) begin
      out_data <= gnt_data;
      out_sel  <= gnt_idx;
    end
  end

`ifdef STREAM_MUX_RR_EN
  // pointer is frozen in manual mode so arbitration resumes where it left off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (load && !man_en)
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr (N=4, WIDTH=8); expectations follow STREAM_MUX_RR_EN.
module tb_stream_mux_rr;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               man_en;
  logic [SELW-1:0]    man_sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;
  logic [SELW+WIDTH-1:0] exp_q[$];

  stream_mux_rr #(.WIDTH(WIDTH), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .man_en(man_en), .man_sel(man_sel),
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [SELW-1:0] sel, input logic [WIDTH-1:0] data);
    exp_q.push_back({sel, data});
    pushed++;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // monitor: every output transfer must match the next expected beat
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      popped++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got sel=%0d data=%0h expected none at %0t", out_sel, out_data, $time);
      end else begin
        logic [SELW+WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("beat_sel", 32'(out_sel), 32'(e[SELW+WIDTH-1:WIDTH]));
        chk("beat_data", 32'(out_data), 32'(e[WIDTH-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SELW-1:0] rr_seq [5];
`ifdef STREAM_MUX_RR_EN
    rr_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    rr_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst_n     = 1'b0;
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = 4'hF;
    man_en    = 1'b0;
    man_sel   = '0;
    out_ready = 1'b1;

    // reset with all channels valid
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);

    // release, stream five beats
    for (int i = 0; i < 5; i++) push(rr_seq[i], 8'h10 + 8'h11 * 8'(rr_seq[i]));
    drive_edge();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_edge();
      if (i == 4) in_valid = 4'h0;
      @(negedge clk);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_sel", 32'(out_sel), 32'(rr_seq[i]));
    end
    drive_edge();
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // backpressure on ch2
    drive_edge();
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    push(2'd2, 8'h32);
    drive_edge();
    in_data[2*WIDTH +: WIDTH] = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h32);
      chk("bp_sel", 32'(out_sel), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      if (i < 4) drive_edge();
    end
    drive_edge();
    out_ready = 1'b1;
    push(2'd2, 8'h77);
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'b0100);
    drive_edge();
    in_valid = 4'h0;
    @(negedge clk);
    chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
    chk("bp_no_bubble_data", 32'(out_data), 32'h77);
    drive_edge();

    // manual mode
    man_en   = 1'b1;
    man_sel  = 2'd2;
    in_data  = {8'h43, 8'h55, 8'hAA, 8'h10};
    in_valid = 4'b0110;
    push(2'd2, 8'h55);
    @(negedge clk);
    chk("man_in_ready", 32'(in_ready), 32'b0100);
    drive_edge();
    in_valid = 4'b0010;
    man_sel  = 2'd3;
    @(negedge clk);
    chk("man_hold_valid", 32'(out_valid), 32'd1);
    chk("man_hold_data", 32'(out_data), 32'h55);
    chk("man_stall_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 2; i++) begin
      drive_edge();
      @(negedge clk);
      chk("man_idle_valid", 32'(out_valid), 32'd0);
      chk("man_ch1_stalled", 32'(in_ready), 32'h0);
    end
    drive_edge();
    in_valid = 4'h0;
    man_en   = 1'b0;
    man_sel  = '0;

    // reset mid-stream with a beat held
    drive_edge();
    in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    drive_edge();
    in_valid = 4'h0;
    @(negedge clk);
    chk("mid_held", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'h00);
    chk("mid_rst_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    drive_edge();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    push(2'd0, 8'h10);
`ifdef STREAM_MUX_RR_EN
    push(2'd1, 8'h21);
`else
    push(2'd0, 8'h10);
`endif
    @(negedge clk);
    chk("mid_restart_ready", 32'(in_ready), 32'b0001);
    drive_edge();
    drive_edge();
    in_valid = 4'h0;
    drive_edge();

    // sparse ch3 pulses
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      in_valid = 4'b1000;
      in_data[3*WIDTH +: WIDTH] = 8'h80 + 8'(i);
      push(2'd3, 8'h80 + 8'(i));
      @(negedge clk);
      chk("sparse_empty", 32'(out_valid), 32'd0);
      chk("sparse_ready", 32'(in_ready), 32'b1000);
      drive_edge();
      in_valid = 4'h0;
      @(negedge clk);
      chk("sparse_valid", 32'(out_valid), 32'd1);
      chk("sparse_sel", 32'(out_sel), 32'd3);
    end
    repeat (3) drive_edge();
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("beat_count", 32'(popped), 32'(pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
